debug_display: RTL and testbench

Debug-readout stage that sits directly downstream of the stack-machine core. It consumes the core's two display words and six debug dump words and presents one selected 16-bit word as four hex digits on the seven-segment displays. A debounced push button steps through the eight words, and a freeze switch snapshots all eight words so a running program can be inspected.

---
 rtl/debug_display_pkg.sv | 26 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/debug_display.sv | 103 ++++++++++
 tb/tb_debug_display.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared types and seven-segment glyph table for the debug readout stage.
package debug_display_pkg;

    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_t;

    typedef logic [2:0] page_t;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned NUM_PAGES = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7f;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return HEX_GLYPH[nib];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low push button; emits a one-cycle
// pulse on each accepted press (released -> pressed transition).
module key_debounce
    import debug_display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       key_sync;
    logic             key_down;
    db_state_t        state;
    logic [CNT_W-1:0] count;
    logic             armed;

    assign key_down = ~key_sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync <= 2'b11;
        end else begin
            key_sync <= {key_sync[0], key_n};
        end
    end

    // After reset the key must be seen released for a full debounce window
    // before presses are accepted, so a button held through reset is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DB_RELEASED;
            count <= '0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (!armed) begin
                if (key_down) begin
                    count <= '0;
                end else if (count == CNT_LAST) begin
                    armed <= 1'b1;
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (key_down == (state == DB_PRESSED)) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                count <= '0;
                state <= (state == DB_PRESSED) ? DB_RELEASED : DB_PRESSED;
                press <= (state == DB_RELEASED);
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_display.sv
// Pages through the core's display/debug words on four hex digits, with a
// freeze switch that snapshots all eight words for inspection.
module debug_display
    import debug_display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_next_n,
    input  logic        sw_freeze,
    input  logic [15:0] seg1,
    input  logic [15:0] seg2,
    input  logic [15:0] dbg0,
    input  logic [15:0] dbg1,
    input  logic [15:0] dbg2,
    input  logic [15:0] dbg3,
    input  logic [15:0] dbg4,
    input  logic [15:0] dbg5,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        led_frozen
);

    logic              press;
    logic [1:0]        frz_sync;
    logic              capture_c;
    page_t             page;
    logic [WORD_W-1:0] live     [NUM_PAGES];
    logic [WORD_W-1:0] snapshot [NUM_PAGES];
    logic [WORD_W-1:0] shown_c;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock (clock),
        .reset (reset),
        .key_n (key_next_n),
        .press (press)
    );

    assign live[0] = seg1;
    assign live[1] = seg2;
    assign live[2] = dbg0;
    assign live[3] = dbg1;
    assign live[4] = dbg2;
    assign live[5] = dbg3;
    assign live[6] = dbg4;
    assign live[7] = dbg5;

    // led_frozen doubles as the registered freeze state used for edge detect and muxing
    assign capture_c = frz_sync[1] & ~led_frozen;
    assign shown_c   = led_frozen ? snapshot[page] : live[page];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frz_sync   <= 2'b00;
            led_frozen <= 1'b0;
            page       <= '0;
        end else begin
            frz_sync   <= {frz_sync[0], sw_freeze};
            led_frozen <= frz_sync[1];
            if (press) begin
                page <= page + page_t'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PAGES); i++) begin
                snapshot[i] <= '0;
            end
        end else if (capture_c) begin
            for (int i = 0; i < int'(NUM_PAGES); i++) begin
                snapshot[i] <= live[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else begin
            hex0 <= hex_glyph(shown_c[3:0]);
            hex1 <= hex_glyph(shown_c[7:4]);
            hex2 <= hex_glyph(shown_c[11:8]);
            hex3 <= hex_glyph(shown_c[15:12]);
            hex4 <= SEG_BLANK;
            hex5 <= hex_glyph({1'b0, page});
        end
    end

endmodule

// File: tb/tb_debug_display.sv
// Directed and randomized checks of paging, debounce, freeze and reset behaviour.
module tb_debug_display;

    logic        clock;
    logic        reset;
    logic        key_next_n;
    logic        sw_freeze;
    logic [15:0] words [8];
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        led_frozen;

    int          tests;
    int          fails;
    int          exp_page;
    logic        frozen_m;
    logic [15:0] snap_m [8];

    debug_display #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_next_n (key_next_n),
        .sw_freeze  (sw_freeze),
        .seg1       (words[0]),
        .seg2       (words[1]),
        .dbg0       (words[2]),
        .dbg1       (words[3]),
        .dbg2       (words[4]),
        .dbg3       (words[5]),
        .dbg4       (words[6]),
        .dbg5       (words[7]),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .led_frozen (led_frozen)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input int n);
        case (n & 15)
            0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
            4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
            8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0e;
        endcase
    endfunction

    function automatic logic [15:0] model_word();
        return frozen_m ? snap_m[exp_page] : words[exp_page];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag);
        logic [15:0] w;
        w = model_word();
        chk({tag, "_hex0"}, 16'(hex0), 16'(glyph(int'(w[3:0]))));
        chk({tag, "_hex1"}, 16'(hex1), 16'(glyph(int'(w[7:4]))));
        chk({tag, "_hex2"}, 16'(hex2), 16'(glyph(int'(w[11:8]))));
        chk({tag, "_hex3"}, 16'(hex3), 16'(glyph(int'(w[15:12]))));
        chk({tag, "_hex4"}, 16'(hex4), 16'h007f);
        chk({tag, "_hex5"}, 16'(hex5), 16'(glyph(exp_page)));
        chk({tag, "_led"},  16'(led_frozen), 16'(frozen_m));
    endtask

    task automatic press_clean();
        key_next_n = 1'b0;
        tick(8);
        key_next_n = 1'b1;
        tick(8);
        exp_page = (exp_page + 1) % 8;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_page   = 0;
        frozen_m   = 1'b0;
        reset      = 1'b1;
        key_next_n = 1'b1;
        sw_freeze  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            words[i]  = 16'($urandom);
            snap_m[i] = 16'h0000;
        end
        words[0] = 16'h1234;

        // Reset: all digits blank
        tick(1);
        chk("rst_hex0", 16'(hex0), 16'h007f);
        chk("rst_hex3", 16'(hex3), 16'h007f);
        chk("rst_hex4", 16'(hex4), 16'h007f);
        chk("rst_hex5", 16'(hex5), 16'h007f);
        chk("rst_led",  16'(led_frozen), 16'h0000);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("post_rst_hex3", 16'(hex3), 16'h0079);
        chk("post_rst_hex0", 16'(hex0), 16'h0019);
        chk("post_rst_hex5", 16'(hex5), 16'h0040);
        chk_disp("post_rst");
        tick(8);

        // Single press: page step lands 7 cycles after the low edge, display one later
        key_next_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 7) chk("press_not_yet", 16'(hex5), 16'(glyph(0)));
            if (i == 8) begin
                exp_page = 1;
                chk_disp("press_step");
            end
        end
        key_next_n = 1'b1;
        tick(10);
        chk_disp("release_no_step");

        // Short bounces are rejected
        for (int r = 0; r < 5; r++) begin
            key_next_n = 1'b0;
            tick(2);
            key_next_n = 1'b1;
            tick(2);
        end
        tick(10);
        chk_disp("bounce");

        // Eight clean presses walk all pages and wrap
        for (int p = 0; p < 8; p++) begin
            press_clean();
            chk_disp($sformatf("walk%0d", p));
        end

        // Freeze on page 2
        while (exp_page != 2) press_clean();
        words[2] = 16'h0010;
        tick(2);
        chk_disp("pre_freeze");
        sw_freeze = 1'b1;
        tick(2);
        chk("freeze_led_early", 16'(led_frozen), 16'h0000);
        tick(1);
        chk("freeze_led_on", 16'(led_frozen), 16'h0001);
        for (int i = 0; i < 8; i++) snap_m[i] = words[i];
        frozen_m = 1'b1;
        tick(2);
        words[2] = 16'h00ff;
        tick(3);
        chk_disp("frozen_hold");
        chk("frozen_hex1", 16'(hex1), 16'h0079);
        sw_freeze = 1'b0;
        tick(2);
        chk("unfreeze_led_early", 16'(led_frozen), 16'h0001);
        tick(1);
        chk("unfreeze_led_off", 16'(led_frozen), 16'h0000);
        chk("unfreeze_still_snap", 16'(hex0), 16'(glyph(0)));
        tick(1);
        frozen_m = 1'b0;
        chk_disp("unfreeze_live");
        chk("unfreeze_hex1", 16'(hex1), 16'h000e);

        // Reset while the key is held on page 5
        while (exp_page != 4) press_clean();
        key_next_n = 1'b0;
        tick(8);
        exp_page = 5;
        chk_disp("held_page5");
        reset = 1'b1;
        tick(1);
        chk("midrst_hex0", 16'(hex0), 16'h007f);
        chk("midrst_hex5", 16'(hex5), 16'h007f);
        tick(2);
        reset    = 1'b0;
        exp_page = 0;
        tick(15);
        chk_disp("held_thru_reset");
        key_next_n = 1'b1;
        tick(12);
        chk_disp("released_after_reset");
        press_clean();
        chk_disp("repress_after_reset");

        // Randomized words, paging and freeze toggling against the model
        for (int it = 0; it < 24; it++) begin
            int n;
            logic f;
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            tick(2);
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) press_clean();
            f = 1'($urandom_range(0, 1));
            if (f != frozen_m) begin
                sw_freeze = f;
                if (f) for (int i = 0; i < 8; i++) snap_m[i] = words[i];
                tick(6);
                frozen_m = f;
            end
            if (frozen_m) begin
                for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
                tick(2);
            end
            chk_disp($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
